cgra_config_sequencer: RTL and testbench

- Sequences a full CGRA run through the top-level config bus (config_addr/config_data) and reset.
- Steps, in order:
  1. Pulses the array reset.
  2. Streams configuration address/data pairs from an upstream valid/ready source, one pair per cycle.
  3. Waits a settle interval.
  4. Enables the pad data drivers for a fixed number of run cycles.
  5. Flags completion.
- Sits between the config-bitstream source (file reader or on-chip ROM/FIFO) and `top`. It replaces ad-hoc bench sequencing.

---
 rtl/cgra_config_sequencer.sv | 116 +++++++++++
 tb/tb_cgra_config_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cgra_config_sequencer.sv
// cgra_config_sequencer: drives a CGRA through reset, config load, settle and run phases.
module cgra_config_sequencer #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RESET_CYCLES  = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RUN_CYCLES    = 10000
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              cgra_reset_out,
  output logic              run_en,
  output logic              busy,
  output logic              config_done,
  output logic              run_done,
  output logic [15:0]       word_count
);
  typedef enum logic [2:0] {S_IDLE, S_RST, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_e;
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] wc_q, wc_d;
  logic cdone_q, cdone_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic ready_q, rst_out_q, run_q, busy_q, rdone_q;
  logic hs;
  assign hs = cfg_valid & ready_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wc_d = wc_q;
    cdone_d = cdone_q;
    addr_d = '0;
    data_d = '0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d = '0;
      cdone_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_d = S_RST;
          cnt_d = '0;
          wc_d = '0;
          cdone_d = 1'b0;
        end
        S_RST: begin
          state_d = (cnt_q == RESET_CYCLES - 1) ? S_LOAD : S_RST;
          cnt_d = (cnt_q == RESET_CYCLES - 1) ? '0 : cnt_q + 32'd1;
        end
        S_LOAD: if (hs) begin
          addr_d = cfg_addr;
          data_d = cfg_data;
          wc_d = &wc_q ? wc_q : wc_q + 16'd1;
          state_d = cfg_last ? S_SETTLE : S_LOAD;
        end
        S_SETTLE: begin
          state_d = (cnt_q == SETTLE_CYCLES - 1) ? S_RUN : S_SETTLE;
          cnt_d = (cnt_q == SETTLE_CYCLES - 1) ? '0 : cnt_q + 32'd1;
          cdone_d = (cnt_q == SETTLE_CYCLES - 1);
        end
        S_RUN: begin
          state_d = (cnt_q == RUN_CYCLES - 1) ? S_DONE : S_RUN;
          cnt_d = (cnt_q == RUN_CYCLES - 1) ? '0 : cnt_q + 32'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // Phase outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wc_q <= '0;
      cdone_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      rst_out_q <= 1'b0;
      run_q <= 1'b0;
      busy_q <= 1'b0;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wc_q <= wc_d;
      cdone_q <= cdone_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ready_q <= state_d == S_LOAD;
      rst_out_q <= state_d == S_RST;
      run_q <= state_d == S_RUN;
      busy_q <= state_d inside {S_RST, S_LOAD, S_SETTLE, S_RUN};
      rdone_q <= state_d == S_DONE;
    end
  end
  assign cfg_ready = ready_q;
  assign config_addr_out = addr_q;
  assign config_data_out = data_q;
  assign cgra_reset_out = rst_out_q;
  assign run_en = run_q;
  assign busy = busy_q;
  assign config_done = cdone_q;
  assign run_done = rdone_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_cgra_config_sequencer.sv
// tb_cgra_config_sequencer: directed checks of the CGRA run sequencer.
module tb_cgra_config_sequencer;
  logic clk_in = 1'b0;
  logic reset_in, start, abort, cfg_valid, cfg_last;
  logic [31:0] cfg_addr, cfg_data;
  logic cfg_ready, cgra_reset_out, run_en, busy, config_done, run_done;
  logic [31:0] config_addr_out, config_data_out;
  logic [15:0] word_count;
  int checks = 0;
  int failures = 0;
  int n;
  int bad;
  cgra_config_sequencer dut (
    .clk_in(clk_in), .reset_in(reset_in), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .config_addr_out(config_addr_out),
    .config_data_out(config_data_out), .cgra_reset_out(cgra_reset_out),
    .run_en(run_en), .busy(busy), .config_done(config_done), .run_done(run_done),
    .word_count(word_count)
  );
  always #5 clk_in = ~clk_in;
  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pair(input logic v, input logic [31:0] a, input logic [31:0] d, input logic l);
    cfg_valid = v;
    cfg_addr = a;
    cfg_data = d;
    cfg_last = l;
  endtask
  initial begin
    reset_in = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pair(1'b0, '0, '0, 1'b0);
    #2;
    chk("por_outputs", {config_addr_out, cfg_ready, cgra_reset_out, run_en, busy, config_done, run_done, word_count}, '0);
    repeat (2) cycle();
    reset_in = 1'b0;
    cycle();
    chk("idle_outputs", {config_data_out, cfg_ready, busy, run_done, word_count}, '0);
    // basic sequence
    start = 1'b1;
    pair(1'b1, 32'h0001_0001, 32'h5, 1'b0);
    cycle();
    start = 1'b0;
    chk("rst_c1", {cgra_reset_out, busy, cfg_ready}, 3'b110);
    cycle();
    chk("rst_c2", cgra_reset_out, 1'b1);
    cycle();
    chk("rst_c3", cgra_reset_out, 1'b1);
    cycle();
    chk("load_entry", {cgra_reset_out, cfg_ready, config_addr_out}, {2'b01, 32'h0});
    cycle();
    chk("pair0", {config_addr_out, config_data_out, word_count}, {32'h0001_0001, 32'h5, 16'd1});
    pair(1'b1, 32'h0002_0001, 32'h7, 1'b0);
    cycle();
    chk("pair1", {config_addr_out, config_data_out, word_count}, {32'h0002_0001, 32'h7, 16'd2});
    pair(1'b1, 32'h0003_0001, 32'h2, 1'b1);
    cycle();
    chk("pair2", {config_addr_out, config_data_out, word_count, cfg_ready}, {32'h0003_0001, 32'h2, 16'd3, 1'b0});
    pair(1'b0, '0, '0, 1'b0);
    cycle();
    chk("settle_bus0", {config_addr_out, config_done}, 33'h0);
    cycle();
    cycle();
    chk("settle_c3", {config_done, run_en}, 2'b00);
    cycle();
    chk("cfg_done_rise", {config_done, run_en}, 2'b11);
    n = 0;
    for (int k = 0; k < 10100 && !run_done; k++) begin
      if (run_en) n++;
      cycle();
    end
    chk("run_len", n, 10000);
    chk("done_state", {run_done, run_en, config_done, busy, word_count}, {4'b1010, 16'd3});
    // restart from DONE, then back-pressure gaps, then abort in RUN
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart", {run_done, config_done, cgra_reset_out, word_count}, {3'b001, 16'd0});
    repeat (3) cycle();
    chk("bp_load", cfg_ready, 1'b1);
    pair(1'b1, 32'h100, 32'hAA, 1'b0);
    cycle();
    chk("bp_pairA", {config_addr_out, config_data_out, word_count}, {32'h100, 32'hAA, 16'd1});
    pair(1'b0, 32'h111, 32'h11, 1'b0);
    cycle();
    chk("bp_gap1", {config_addr_out, config_data_out}, 64'h0);
    cycle();
    chk("bp_gap2", {config_addr_out, config_data_out, word_count}, {64'h0, 16'd1});
    pair(1'b1, 32'h200, 32'hBB, 1'b1);
    cycle();
    chk("bp_pairB", {config_addr_out, config_data_out, word_count, cfg_ready}, {32'h200, 32'hBB, 16'd2, 1'b0});
    pair(1'b0, '0, '0, 1'b0);
    cycle();
    chk("bp_nodup", {config_addr_out, word_count}, {32'h0, 16'd2});
    repeat (3) cycle();
    chk("bp_run", run_en, 1'b1);
    repeat (499) cycle();
    chk("run_500", run_en, 1'b1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_run", {run_en, config_done, busy, cgra_reset_out, run_done, word_count}, {5'b0, 16'd2});
    // abort colliding with a handshake in LOAD
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    pair(1'b1, 32'h300, 32'hCC, 1'b0);
    cycle();
    chk("ab_pair", {config_addr_out, word_count}, {32'h300, 16'd1});
    pair(1'b1, 32'h400, 32'hDD, 1'b0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    pair(1'b0, '0, '0, 1'b0);
    chk("ab_drop", {config_addr_out, config_data_out, word_count, busy, cfg_ready}, {64'h0, 16'd1, 2'b00});
    cycle();
    chk("ab_idle", {config_addr_out, word_count, busy}, {32'h0, 16'd1, 1'b0});
    // ignored start in LOAD, then async reset mid-LOAD
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    pair(1'b1, 32'h500, 32'hEE, 1'b0);
    cycle();
    pair(1'b0, '0, '0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("ign_start", {cfg_ready, busy, cgra_reset_out, word_count}, {3'b110, 16'd1});
    pair(1'b1, 32'h600, 32'hFF, 1'b0);
    cycle();
    pair(1'b0, '0, '0, 1'b0);
    chk("pre_areset", {config_addr_out, word_count}, {32'h600, 16'd2});
    #3 reset_in = 1'b1;
    #1;
    chk("areset", {config_addr_out, config_data_out, word_count, cfg_ready, busy}, '0);
    cycle();
    reset_in = 1'b0;
    // saturation through a clean post-reset sequence
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("sat_reset", cgra_reset_out, 1'b1);
    repeat (3) cycle();
    chk("sat_load", cfg_ready, 1'b1);
    bad = 0;
    for (int i = 0; i <= 65536; i++) begin
      pair(1'b1, i + 1, i ^ 32'hA5A5_0000, i == 65536);
      cycle();
      if (config_addr_out !== i + 1 || config_data_out !== (i ^ 32'hA5A5_0000)) bad++;
    end
    pair(1'b0, '0, '0, 1'b0);
    chk("sat_fwd_errors", bad, 0);
    chk("sat_count", {word_count, cfg_ready}, {16'hFFFF, 1'b0});
    repeat (4) cycle();
    chk("sat_run", {config_done, run_en, busy}, 3'b111);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("sat_abort", {busy, run_en, config_done, word_count}, {3'b000, 16'hFFFF});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
